onehot_decoder_seq: RTL and testbench



---
 rtl/onehot_decoder_seq.sv | 114 +++++++++++
 tb/tb_onehot_decoder_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - registered one-hot decoder with range check and autonomous scan mode
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         global enable; low freezes state and outputs, clears pulses
//   mode       0 = decode, 1 = scan
//   sel_valid  sel is valid this cycle (decode mode only)
//   sel        output index to decode
//   dwell      cycles-minus-one each scan output is held
//   res        registered one-hot output (or all zeros)
//   res_valid  res holds a valid one-hot value
//   wrap       one-cycle pulse when scan leaves index NUM_OUT-1
//   err        one-cycle pulse on out-of-range sel
module onehot_decoder_seq #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NUM_OUT-1:0] res,
    output logic               res_valid,
    output logic               wrap,
    output logic               err
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OUT - 1);
    localparam logic [NUM_OUT-1:0] ONE      = NUM_OUT'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [DWELL_W-1:0] dcnt;
    logic               sel_in_range;
    logic [IDX_W-1:0]   idx_next;

    // When every sel encoding maps to an output, the comparator is omitted
    // and err can never fire.
    generate
        if (NUM_OUT < (1 << SEL_W)) begin : g_range_check
            localparam logic [SEL_W:0] NUM_OUT_V = (SEL_W + 1)'(NUM_OUT);
            assign sel_in_range = ({1'b0, sel} < NUM_OUT_V);
        end else begin : g_no_range_check
            assign sel_in_range = 1'b1;
        end
    endgenerate

    assign idx_next = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            dcnt      <= '0;
            res       <= '0;
            res_valid <= 1'b0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else if (!en) begin
            // Freeze everything; pulses must not stretch across a freeze.
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (mode && (state != ST_SCAN)) begin
                state     <= ST_SCAN;
                idx       <= '0;
                dcnt      <= dwell;
                res       <= ONE;
                res_valid <= 1'b1;
            end else if (!mode && (state == ST_SCAN)) begin
                state     <= ST_IDLE;
                res       <= '0;
                res_valid <= 1'b0;
            end else if (!mode) begin
                if (sel_valid) begin
                    if (sel_in_range) begin
                        state     <= ST_HOLD;
                        res       <= ONE << sel;
                        res_valid <= 1'b1;
                    end else begin
                        state     <= ST_IDLE;
                        res       <= '0;
                        res_valid <= 1'b0;
                        err       <= 1'b1;
                    end
                end
            end else begin
                // Scanning: dwell is only sampled on reload, so a mid-scan
                // change never shortens the output currently shown.
                if (dcnt != '0) begin
                    dcnt <= dcnt - DWELL_W'(1);
                end else begin
                    idx  <= idx_next;
                    dcnt <= dwell;
                    res  <= ONE << idx_next;
                    wrap <= (idx == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb/tb_onehot_decoder_seq.sv - scoreboard testbench for onehot_decoder_seq
module tb_onehot_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       mode = 1'b0;
    logic       sel_valid = 1'b0;
    logic [2:0] sel = '0;
    logic [3:0] dwell = '0;

    logic [7:0] res8;
    logic       rv8, wrap8, err8;
    logic [5:0] res6;
    logic       rv6, wrap6, err6;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       v;
        logic       e;
        logic       w;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    onehot_decoder_seq #(.SEL_W(3), .NUM_OUT(8), .DWELL_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel), .dwell(dwell), .res(res8), .res_valid(rv8), .wrap(wrap8), .err(err8)
    );

    onehot_decoder_seq #(.SEL_W(3), .NUM_OUT(6), .DWELL_W(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid),
        .sel(sel), .dwell(dwell), .res(res6), .res_valid(rv6), .wrap(wrap6), .err(err6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] r, input logic v, input logic e, input logic w);
        exp_t x;
        x.res = r; x.v = v; x.e = e; x.w = w;
        sb.push_back(x);
    endtask

    // Expected 8-output scan trace: cycle k after entry shows index
    // (k / (d+1)) % 8; wrap marks each return to index 0.
    task automatic push_scan(input int d, input int k0, input int k1);
        logic [7:0] one8;
        int p;
        one8 = 8'h01;
        p = 8 * (d + 1);
        for (int k = k0; k <= k1; k++)
            push_exp(one8 << ((k / (d + 1)) % 8), 1'b1, 1'b0, (k > 0) && (k % p == 0));
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        tick();
        tick();
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({res8, rv8, err8, wrap8} !== e) begin
            failures++;
            $display("FAIL reset8 got res=%h v=%b e=%b w=%b want res=%h v=%b e=%b w=%b",
                     res8, rv8, err8, wrap8, e.res, e.v, e.e, e.w);
        end
        e = sb.pop_front();
        checks++;
        if ({2'b00, res6, rv6, err6, wrap6} !== e) begin
            failures++;
            $display("FAIL reset6 got res=%h v=%b e=%b w=%b want res=%h v=%b e=%b w=%b",
                     res6, rv6, err6, wrap6, e.res, e.v, e.e, e.w);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        exp_t e;
        logic [7:0] one8;
        one8 = 8'h01;
        for (int s = 0; s < 8; s++) begin
            sel_valid = 1'b1;
            sel = 3'(s);
            push_exp(one8 << s, 1'b1, 1'b0, 1'b0);
            tick();
            e = sb.pop_front();
            checks++;
            if ({res8, rv8, err8, wrap8} !== e) begin
                failures++;
                $display("FAIL decode sel=%0d got res=%h v=%b e=%b w=%b want res=%h v=%b e=%b w=%b",
                         s, res8, rv8, err8, wrap8, e.res, e.v, e.e, e.w);
            end
        end
        // sel_valid low holds; en low ignores sel_valid.
        sel_valid = 1'b0;
        sel = 3'd1;
        for (int c = 0; c < 4; c++) begin
            if (c >= 2) begin
                en = 1'b0;
                sel_valid = 1'b1;
            end
            push_exp(8'h80, 1'b1, 1'b0, 1'b0);
            tick();
            e = sb.pop_front();
            checks++;
            if ({res8, rv8, err8, wrap8} !== e) begin
                failures++;
                $display("FAIL decode_hold c=%0d got res=%h v=%b want res=%h v=%b",
                         c, res8, rv8, e.res, e.v);
            end
        end
        en = 1'b1;
        sel_valid = 1'b0;
    endtask

    task automatic test_out_of_range();
        exp_t e;
        logic [2:0] sels [5] = '{3'd5, 3'd6, 3'd0, 3'd0, 3'd7};
        logic       vals [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_t       want [5];
        want[0] = '{res: 8'h20, v: 1'b1, e: 1'b0, w: 1'b0};
        want[1] = '{res: 8'h00, v: 1'b0, e: 1'b1, w: 1'b0};
        want[2] = '{res: 8'h00, v: 1'b0, e: 1'b0, w: 1'b0};
        want[3] = '{res: 8'h01, v: 1'b1, e: 1'b0, w: 1'b0};
        want[4] = '{res: 8'h00, v: 1'b0, e: 1'b1, w: 1'b0};
        for (int i = 0; i < 5; i++) begin
            sel = sels[i];
            sel_valid = vals[i];
            sb.push_back(want[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if ({2'b00, res6, rv6, err6, wrap6} !== e) begin
                failures++;
                $display("FAIL range6 step=%0d got res=%h v=%b e=%b want res=%h v=%b e=%b",
                         i, res6, rv6, err6, e.res, e.v, e.e);
            end
        end
        sel_valid = 1'b0;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if ({2'b00, res6, rv6, err6, wrap6} !== e) begin
            failures++;
            $display("FAIL range6_pulse got res=%h v=%b e=%b want res=%h v=%b e=%b",
                     res6, rv6, err6, e.res, e.v, e.e);
        end
    endtask

    task automatic test_scan(input int d);
        exp_t e;
        int n;
        mode = 1'b1;
        dwell = 4'(d);
        n = 2 * 8 * (d + 1) + 1;
        push_scan(d, 0, n - 1);
        for (int k = 0; k < n; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({res8, rv8, err8, wrap8} !== e) begin
                failures++;
                $display("FAIL scan d=%0d k=%0d got res=%h v=%b w=%b want res=%h v=%b w=%b",
                         d, k, res8, rv8, wrap8, e.res, e.v, e.w);
            end
        end
        mode = 1'b0;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if ({res8, rv8, err8, wrap8} !== e) begin
            failures++;
            $display("FAIL scan_exit d=%0d got res=%h v=%b want res=%h v=%b",
                     d, res8, rv8, e.res, e.v);
        end
    endtask

    task automatic test_freeze();
        exp_t e;
        mode = 1'b1;
        dwell = 4'd2;
        push_scan(2, 0, 10);
        for (int k = 0; k <= 10; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({res8, rv8, err8, wrap8} !== e) begin
                failures++;
                $display("FAIL freeze_pre k=%0d got res=%h w=%b want res=%h w=%b",
                         k, res8, wrap8, e.res, e.w);
            end
        end
        en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            push_exp(8'h08, 1'b1, 1'b0, 1'b0);
            tick();
            e = sb.pop_front();
            checks++;
            if ({res8, rv8, err8, wrap8} !== e) begin
                failures++;
                $display("FAIL freeze_hold c=%0d got res=%h w=%b want res=%h w=%b",
                         c, res8, wrap8, e.res, e.w);
            end
        end
        en = 1'b1;
        push_scan(2, 11, 12);
        for (int k = 11; k <= 12; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({res8, rv8, err8, wrap8} !== e) begin
                failures++;
                $display("FAIL freeze_resume k=%0d got res=%h want res=%h", k, res8, e.res);
            end
        end
    endtask

    task automatic test_mode_switch();
        exp_t e;
        mode = 1'b0;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        e = sb.pop_front();
        checks++;
        if ({res8, rv8, err8, wrap8} !== e) begin
            failures++;
            $display("FAIL mode_exit got res=%h v=%b want res=%h v=%b", res8, rv8, e.res, e.v);
        end
        mode = 1'b1;
        push_scan(2, 0, 3);
        for (int k = 0; k <= 3; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({res8, rv8, err8, wrap8} !== e) begin
                failures++;
                $display("FAIL mode_reenter k=%0d got res=%h want res=%h", k, res8, e.res);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        #2;
        rst_n = 1'b0;
        #1;
        // Still well before the next rising edge.
        push_exp(8'h00, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({res8, rv8, err8, wrap8} !== e) begin
            failures++;
            $display("FAIL async_reset got res=%h v=%b want res=%h v=%b", res8, rv8, e.res, e.v);
        end
        tick();
        rst_n = 1'b1;
        dwell = 4'd1;
        push_scan(1, 0, 3);
        for (int k = 0; k <= 3; k++) begin
            tick();
            e = sb.pop_front();
            checks++;
            if ({res8, rv8, err8, wrap8} !== e) begin
                failures++;
                $display("FAIL reset_restart k=%0d got res=%h v=%b want res=%h v=%b",
                         k, res8, rv8, e.res, e.v);
            end
        end
        mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode();
        test_out_of_range();
        test_scan(2);
        test_scan(0);
        test_freeze();
        test_mode_switch();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
